spi_word_receiver: RTL
======================

Name: spi_word_receiver

Overview:
Parametrised SPI slave receiver, successor to the byte-level SPI readers. Samples an external SPI bus (any CPOL/CPHA mode, configurable word width and bit order) in the FPGA system clock domain through synchronisers. Assembles received words into an internal first-word-fall-through FIFO with a valid/ready drain interface. Shifts a status word, then a loopback echo, back on MISO so the MCU can check link integrity.

Parameters:
WORD_WIDTH, 8, bits per SPI word (range 4..32)
FIFO_DEPTH, 4, receive FIFO entries (power of two, 2..64)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB first on both MOSI and MISO, 0 = LSB first
SYNC_STAGES, 2, flip-flop stages on spi_sck, spi_cs_n and spi_mosi (minimum 2)

Ports:
- clk  in  1  system clock; must run at least 8x the SCK frequency
- rst_n  in  1  asynchronous active-low reset
- spi_cs_n  in  1  chip select, active low, asynchronous to clk
- spi_sck  in  1  SPI clock, asynchronous to clk
- spi_mosi  in  1  SPI data in
- spi_miso  out  1  SPI data out
- rx_data  out  WORD_WIDTH  FIFO head word
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts head word
- fifo_level  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- overflow_clr  in  1  clears overflow
- frame_abort  out  1  1-cycle pulse: CS deasserted with a partial word

Behaviour:
- Reset:
  - Asynchronous and active-low. While rst_n is low: all outputs 0, FIFO empty, FSM in IDLE, synchroniser registers loaded with idle values (cs_n = 1, sck = CPOL).
- Synchronisation:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - An edge detector on synced SCK produces one-cycle lead_edge and trail_edge strobes.
  - Leading edge is rising when CPOL = 0 and falling when CPOL = 1.
  - Sample strobe is lead_edge when CPHA = 0, trail_edge when CPHA = 1. Shift strobe is the other edge.
- FSM:
  - IDLE:
    - spi_miso = 0; SCK edges ignored.
    - Synced cs_n falling -> ACTIVE: bit counter = 0, tx shift register loaded with the status word, first tx bit driven on spi_miso in the same cycle.
    - The MCU must hold CS low SYNC_STAGES+2 clk cycles before the first SCK edge.
  - ACTIVE:
    - Each sample strobe shifts synced MOSI into rx shift register (MSB_FIRST selects shift direction) and increments the bit counter.
    - Each shift strobe advances the tx shift register onto spi_miso. For CPHA = 0, a shift strobe arriving before the first sample strobe is ignored.
    - When the counter reaches WORD_WIDTH: counter wraps to 0 and the assembled word is pushed to the FIFO on the next clk edge.
    - At that same push, the tx register reloads with the just-received word (echo) for the next word period.
    - Synced cs_n rising -> IDLE.
    - If the counter is nonzero when CS rises, the partial word is discarded and frame_abort pulses for 1 cycle.
- Status word:
  - Bit WORD_WIDTH-1 = overflow.
  - Low bits = fifo_level sampled at CS assertion, zero-extended.
- Latency:
  - Final sampling SCK edge at the pin -> rx_valid high = SYNC_STAGES+3 clk rising edges when the FIFO was empty.
- FIFO:
  - First-word fall-through; rx_data is valid whenever rx_valid = 1. rx_data holds its value while rx_valid = 1 and rx_ready = 0.
  - Pop occurs when rx_valid & rx_ready.
  - Push with FIFO full and no pop: word dropped, overflow set, fifo_level unchanged.
  - Push with FIFO full and pop in the same cycle: push accepted, level unchanged.
  - Push and pop on an empty FIFO are impossible in the same cycle (rx_valid = 0).
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow flag:
  - overflow_clr clears overflow next cycle.
  - If a drop occurs in the same cycle as overflow_clr, set wins.
- CS glitches:
  - A CS pulse shorter than SYNC_STAGES clk cycles may be missed; this is allowed.
  - A CS high of at least 2 clk cycles between frames must be detected.
- Reset mid-frame:
  - rst_n low during a transfer empties the FIFO and returns the FSM to IDLE.
  - After reset releases with CS still low, the block stays in IDLE until it sees a fresh CS falling edge (no partial capture).

Test Plan:
- Mode 0, WORD_WIDTH = 8, MSB first: send 0x45, 0x69, 0x6B in one frame, rx_ready = 1 -> rx_data 0x45, 0x69, 0x6B in order; MISO returns 0x00 (status, empty FIFO), 0x45, 0x69.
- Mode 3, LSB first, WORD_WIDTH = 12: send 0xA5C -> rx_data = 0xA5C; level returns to 0 after the pop.
- CS deasserted after 5 bits of a word following one complete word 0x3C -> frame_abort pulses once, only 0x3C in the FIFO; the next frame's 0x81 is received correctly.
- FIFO_DEPTH = 4, rx_ready = 0: send 6 words 0x01..0x06 -> fifo_level = 4, overflow = 1, FIFO drains 0x01..0x04; next frame's status word = 0x84.
- FIFO full with rx_ready = 1 held during a push -> no drop, overflow stays 0. Separately, overflow_clr asserted in the same cycle as a drop -> overflow remains 1.
- rst_n pulsed low mid-byte with CS held low -> all outputs 0; bits after release not captured until CS toggles high then low.

Source files
------------

// File: rtl/spi_word_receiver_if.sv
// Receive-word stream between the SPI word receiver and its consumer.
// The master side sources words; the slave side drains them with rx_ready.
interface spi_word_receiver_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_word_receiver.sv
// SPI slave word receiver: synchronised SCK/CS/MOSI sampling, FWFT receive FIFO,
// and a status-then-echo word stream shifted back on MISO.
module spi_word_receiver #(
    parameter int WORD_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             spi_cs_n,
    input  logic                             spi_sck,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    spi_word_receiver_if.master              rx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             overflow,
    input  logic                             overflow_clr,
    output logic                             frame_abort
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic SCK_IDLE = (CPOL != 0);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, fill_q, fill_d;
    logic armed_q, armed_d, cs_prev_q, cs_prev_d, sck_prev_q, sck_prev_d;
    logic sample_q, sample_d, shift_q, shift_d;
    logic [0:0] state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic push_q, push_d, frame_abort_q, frame_abort_d, overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [WORD_WIDTH-1:0] rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d, status_word;
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic cs_s, sck_s, mosi_s, cs_fall, cs_rise, sck_rise, sck_fall;
    logic lead_edge, trail_edge, rx_valid, full, pop, accept, drop;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // armed_q gates CS falling edges until a genuine high has been seen, so a
    // reset released mid-frame never starts a partial capture.
    assign cs_fall    = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise    = ~cs_prev_q & cs_s;
    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign lead_edge  = (CPOL != 0) ? sck_fall : sck_rise;
    assign trail_edge = (CPOL != 0) ? sck_rise : sck_fall;

    assign rx_valid    = (count_q != '0);
    assign full        = (count_q == LW'(FIFO_DEPTH));
    assign pop         = rx_valid & rx.rx_ready;
    assign accept      = push_q & (~full | pop);
    assign drop        = push_q & full & ~pop;
    assign rx.rx_valid = rx_valid;
    assign rx.rx_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level  = count_q;
    assign overflow    = overflow_q;
    assign frame_abort = frame_abort_q;
    assign spi_miso    = (state_q == ST_ACTIVE) &
                         ((MSB_FIRST != 0) ? tx_sr_q[WORD_WIDTH-1] : tx_sr_q[0]);

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        sample_d    = (CPHA != 0) ? trail_edge : lead_edge;
        shift_d     = (CPHA != 0) ? lead_edge : trail_edge;

        status_word = '0;
        status_word[WORD_WIDTH-1] = overflow_q;
        for (int i = 0; i < WORD_WIDTH - 1 && i < LW; i++) begin
            status_word[i] = count_q[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        push_d        = 1'b0;
        frame_abort_d = 1'b0;
        rx_sr_d       = rx_sr_q;
        tx_sr_d       = tx_sr_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    tx_sr_d   = status_word;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    frame_abort_d = (bit_cnt_q != '0);
                end else begin
                    if (sample_q) begin
                        rx_sr_d = (MSB_FIRST != 0) ? {rx_sr_q[WORD_WIDTH-2:0], mosi_s}
                                                   : {mosi_s, rx_sr_q[WORD_WIDTH-1:1]};
                        if (bit_cnt_q == CW'(WORD_WIDTH - 1)) begin
                            bit_cnt_d = '0;
                            push_d    = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    // A shift at bit count 0 would skip the first bit of the
                    // word currently loaded, in either CPHA mode.
                    if (push_q) begin
                        tx_sr_d = rx_sr_q;
                    end else if (shift_q && (bit_cnt_q != '0)) begin
                        tx_sr_d = (MSB_FIRST != 0) ? {tx_sr_q[WORD_WIDTH-2:0], 1'b0}
                                                   : {1'b0, tx_sr_q[WORD_WIDTH-1:1]};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            mem_d[wr_ptr_q] = rx_sr_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !accept) begin
            count_d = count_q - LW'(1);
        end
        overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q     <= '1;
            sck_sync_q    <= {SYNC_STAGES{SCK_IDLE}};
            mosi_sync_q   <= '0;
            fill_q        <= '0;
            armed_q       <= 1'b0;
            cs_prev_q     <= 1'b1;
            sck_prev_q    <= SCK_IDLE;
            sample_q      <= 1'b0;
            shift_q       <= 1'b0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            push_q        <= 1'b0;
            frame_abort_q <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            cs_sync_q     <= cs_sync_d;
            sck_sync_q    <= sck_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            fill_q        <= fill_d;
            armed_q       <= armed_d;
            cs_prev_q     <= cs_prev_d;
            sck_prev_q    <= sck_prev_d;
            sample_q      <= sample_d;
            shift_q       <= shift_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            push_q        <= push_d;
            frame_abort_q <= frame_abort_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Datapath registers carry no reset; MISO and rx_data are gated by control state.
    always_ff @(posedge clk) begin
        rx_sr_q <= rx_sr_d;
        tx_sr_q <= tx_sr_d;
        mem_q   <= mem_d;
    end
endmodule
